avalon_mm_burst_ram_slave: RTL
==============================

Name: avalon_mm_burst_ram_slave

Overview:
Avalon-MM burst-capable slave that stands directly downstream of the Avalon-MM master stage and serves its write and read commands. It is a small word-addressed RAM with per-byte write enables and pipelined, fixed-latency read responses. It uses waitrequest backpressure while a read burst is being returned. It replaces the slave BFM as the real endpoint in the system testbench, so the existing command and response checking runs against RTL.

Parameters:
ADDR_W, 12, byte address width
DATA_W, 32, data width; must equal 8*NUM_SYMBOLS
NUM_SYMBOLS, 4, bytes per word and byteenable width
BURST_W, 4, burstcount width
DEPTH, 8, RAM words; power of two; span is DEPTH*NUM_SYMBOLS bytes
READ_LATENCY, 2, cycles from read-command acceptance to the first readdatavalid; legal range 1..4

Ports:
clock  in  1  system clock; all logic on the rising edge
reset_n  in  1  asynchronous active-low reset
avs_address  in  ADDR_W  byte address; sampled only on command acceptance
avs_read  in  1  read request
avs_write  in  1  write request or write beat
avs_writedata  in  DATA_W  write data
avs_byteenable  in  NUM_SYMBOLS  per-byte write enable
avs_burstcount  in  BURST_W  beats in the burst; sampled on command acceptance
avs_waitrequest  out  1  stall; the master holds its request while this is high
avs_readdata  out  DATA_W  read data
avs_readdatavalid  out  1  marks a valid readdata beat

Behaviour:
- Word index = avs_address[log2(NUM_SYMBOLS)+log2(DEPTH)-1 : log2(NUM_SYMBOLS)].
  - Low byte-offset bits are ignored.
  - Upper bits are ignored, so addresses alias modulo the span.
- Burst beat k uses word (start+k) mod DEPTH, i.e. bursts wrap around the RAM.
- A burstcount of 0 is treated as 1. Values up to 2^BURST_W-1 are honoured as given, with no clamp.
- Reset (asynchronous assertion, synchronous-release-safe):
  - state=IDLE; RAM cleared to 0; read pipeline flushed.
  - avs_waitrequest=1, avs_readdatavalid=0, avs_readdata=0.
  - In the first clock after reset_n rises, waitrequest goes to 0.
- States:
  - IDLE: waitrequest=0.
    - avs_write=1: accept the first write beat and perform the write this edge. If burstcount>1, go to WR_BURST with remaining=N-1; otherwise stay in IDLE.
    - avs_write=0, avs_read=1: accept a read of N beats at cycle T and go to RD_BURST.
    - avs_write=1 and avs_read=1 in the same cycle: the write wins and the read is dropped.
  - WR_BURST: waitrequest=0.
    - Each cycle with avs_write=1 writes one beat to the next word and decrements remaining.
    - avs_address and avs_burstcount are ignored on these beats.
    - Gaps (avs_write=0) are allowed and stall the burst without limit.
    - avs_read is ignored in this state.
    - Return to IDLE on the edge that writes the last beat.
  - RD_BURST: waitrequest=1.
    - The RAM is read one word per cycle for N cycles, starting at T+1, into a READ_LATENCY-deep valid/data pipeline.
    - Beat i appears with readdatavalid=1 in cycle T+READ_LATENCY+i, i=0..N-1. Beats are back to back with no gaps.
    - waitrequest stays 1 through cycle T+READ_LATENCY+N-1 and is 0 in cycle T+READ_LATENCY+N; the state is IDLE again at that point.
- Byte write: byte b of the word is updated only when byteenable[b]=1.
- Read-after-write: a read accepted the cycle after a write completes returns the new data.
- avs_readdata holds its last value while readdatavalid=0.
- Reset mid-burst: all in-flight read beats are discarded, with no readdatavalid after reset. A partial write burst is abandoned; beats already written are lost because the RAM is cleared.

Test Plan:
1. Reset check: hold reset_n=0 → waitrequest=1, readdatavalid=0; release reset_n → waitrequest=0 on the next edge; a read of word 3 returns 0.
2. Single write then read (READ_LATENCY=2):
   - Write 0xDEADBEEF at address 0x008, byteenable 0xF.
   - Read 0x008 accepted at T → readdatavalid only at T+2 with 0xDEADBEEF.
   - waitrequest=1 at T+1..T+2 and 0 at T+3.
3. Byte-enable write burst:
   - Burst of 4 at 0x010, data 0x11111111..0x44444444, with one idle cycle between beats 2 and 3; beat 1 byteenable=0x3, others 0xF.
   - Read burst of 4 → 0x11111111, 0x00002222, 0x33333333, 0x44444444.
4. Wrap-around and alias:
   - Write words 0..7 with value 0xA0+k.
   - Read burst of 8 at address 0x118 (word 6) → A6, A7, A0..A5 on eight consecutive readdatavalid cycles; no extra beats.
5. Simultaneous read and write in IDLE: write 0x55 to 0x004 with avs_read=1 in the same cycle → word 1=0x55; no readdatavalid is ever produced.
6. Reset mid read burst: pulse reset_n low two cycles after accepting an 8-beat read → readdatavalid=0 from reset onward; a subsequent read returns 0.

Source files
------------

// File: rtl/avalon_mm_burst_ram_slave_if.sv
// rtl/avalon_mm_burst_ram_slave_if.sv - Avalon-MM burst bus between master stage and RAM slave
interface avalon_mm_burst_ram_slave_if #(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 32,
    parameter int NUM_SYMBOLS = 4,
    parameter int BURST_W     = 4
);
    logic [ADDR_W-1:0]      avs_address;
    logic                   avs_read;
    logic                   avs_write;
    logic [DATA_W-1:0]      avs_writedata;
    logic [NUM_SYMBOLS-1:0] avs_byteenable;
    logic [BURST_W-1:0]     avs_burstcount;
    logic                   avs_waitrequest;
    logic [DATA_W-1:0]      avs_readdata;
    logic                   avs_readdatavalid;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable, avs_burstcount,
        input  avs_waitrequest, avs_readdata, avs_readdatavalid
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable, avs_burstcount,
        output avs_waitrequest, avs_readdata, avs_readdatavalid
    );
endinterface

// File: rtl/avalon_mm_burst_ram_slave.sv
// rtl/avalon_mm_burst_ram_slave.sv - burst-capable Avalon-MM RAM slave with fixed-latency reads
module avalon_mm_burst_ram_slave #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int NUM_SYMBOLS  = 4,
    parameter int BURST_W      = 4,
    parameter int DEPTH        = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic                          clock,
    input  logic                          reset_n,
    avalon_mm_burst_ram_slave_if.slave    avs
);
    localparam int OFF_W = $clog2(NUM_SYMBOLS);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int DR_W  = BURST_W + 3;

    typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;

    state_t               state_q;
    logic                 waitreq_q;
    logic [DATA_W-1:0]    mem_q [DEPTH];
    logic [IDX_W-1:0]     wr_idx_q;
    logic [IDX_W-1:0]     rd_idx_q;
    logic [BURST_W-1:0]   wr_left_q;
    logic [BURST_W-1:0]   rd_left_q;
    logic [DR_W-1:0]      drain_q;
    logic [READ_LATENCY-1:0] pipe_valid_q;
    logic [DATA_W-1:0]    pipe_data_q [READ_LATENCY];

    logic [IDX_W-1:0]     cmd_idx_d;
    logic [BURST_W-1:0]   burst_len_d;
    logic                 accept_d;
    logic                 do_write_d;
    logic [IDX_W-1:0]     wr_idx_d;
    logic                 rd_start_d;
    logic                 rd_issue_d;
    logic [IDX_W-1:0]     rd_idx_d;
    logic [DATA_W-1:0]    wr_word_d;

    // Offset bits and bits above the span only alias; they never select storage.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{avs.avs_address[ADDR_W-1:OFF_W+IDX_W], avs.avs_address[OFF_W-1:0]};

    always_comb begin
        cmd_idx_d   = avs.avs_address[OFF_W+IDX_W-1:OFF_W];
        burst_len_d = (avs.avs_burstcount == '0) ? BURST_W'(1) : avs.avs_burstcount;
        accept_d    = (state_q == IDLE) && !waitreq_q;
        do_write_d  = avs.avs_write && (accept_d || (state_q == WR_BURST));
        wr_idx_d    = (state_q == IDLE) ? cmd_idx_d : wr_idx_q;
        rd_start_d  = accept_d && !avs.avs_write && avs.avs_read;
        rd_issue_d  = rd_start_d || ((state_q == RD_BURST) && (rd_left_q != '0));
        rd_idx_d    = rd_start_d ? cmd_idx_d : rd_idx_q;
        wr_word_d   = mem_q[wr_idx_d];
        for (int b = 0; b < NUM_SYMBOLS; b++) begin
            if (avs.avs_byteenable[b]) begin
                wr_word_d[8*b +: 8] = avs.avs_writedata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            waitreq_q    <= 1'b1;
            wr_idx_q     <= '0;
            rd_idx_q     <= '0;
            wr_left_q    <= '0;
            rd_left_q    <= '0;
            drain_q      <= '0;
            pipe_valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            for (int k = 0; k < READ_LATENCY; k++) begin
                pipe_data_q[k] <= '0;
            end
        end else begin
            if (do_write_d) begin
                mem_q[wr_idx_d] <= wr_word_d;
            end

            // The first beat is read on the accepting edge so beat 0 lands exactly READ_LATENCY cycles later.
            pipe_valid_q[0] <= rd_issue_d;
            if (rd_issue_d) begin
                pipe_data_q[0] <= mem_q[rd_idx_d];
            end
            for (int k = 1; k < READ_LATENCY; k++) begin
                pipe_valid_q[k] <= pipe_valid_q[k-1];
                if (pipe_valid_q[k-1]) begin
                    pipe_data_q[k] <= pipe_data_q[k-1];
                end
            end

            case (state_q)
                IDLE: begin
                    waitreq_q <= 1'b0;
                    if (accept_d && avs.avs_write) begin
                        if (burst_len_d > BURST_W'(1)) begin
                            wr_idx_q  <= cmd_idx_d + IDX_W'(1);
                            wr_left_q <= burst_len_d - BURST_W'(1);
                            state_q   <= WR_BURST;
                        end
                    end else if (rd_start_d) begin
                        rd_idx_q  <= cmd_idx_d + IDX_W'(1);
                        rd_left_q <= burst_len_d - BURST_W'(1);
                        drain_q   <= DR_W'(READ_LATENCY) + DR_W'(burst_len_d) - DR_W'(1);
                        waitreq_q <= 1'b1;
                        state_q   <= RD_BURST;
                    end
                end
                WR_BURST: begin
                    if (avs.avs_write) begin
                        wr_idx_q  <= wr_idx_q + IDX_W'(1);
                        wr_left_q <= wr_left_q - BURST_W'(1);
                        if (wr_left_q == BURST_W'(1)) begin
                            state_q <= IDLE;
                        end
                    end
                end
                RD_BURST: begin
                    if (rd_left_q != '0) begin
                        rd_idx_q  <= rd_idx_q + IDX_W'(1);
                        rd_left_q <= rd_left_q - BURST_W'(1);
                    end
                    // drain_q counts the stalled cycles until the last beat has been presented.
                    if (drain_q == DR_W'(1)) begin
                        waitreq_q <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        drain_q <= drain_q - DR_W'(1);
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    waitreq_q <= 1'b0;
                end
            endcase
        end
    end

    assign avs.avs_waitrequest   = waitreq_q;
    assign avs.avs_readdata      = pipe_data_q[READ_LATENCY-1];
    assign avs.avs_readdatavalid = pipe_valid_q[READ_LATENCY-1];
endmodule
